// File: rtl/pci_mailbox_pkg.sv
// Shared definitions for the PCI host/local mailbox: register offsets,
// STATUS bit positions and the set of implemented IRQ_MASK bits.
package pci_mailbox_pkg;

    typedef enum logic [2:0] {
        MBOX_H2L_DATA     = 3'd0,
        MBOX_L2H_DATA     = 3'd1,
        MBOX_STATUS       = 3'd2,
        MBOX_IRQ_MASK     = 3'd3,
        MBOX_DOORBELL_OUT = 3'd4,
        MBOX_COUNTS       = 3'd5,
        MBOX_RSVD6        = 3'd6,
        MBOX_RSVD7        = 3'd7
    } mbox_reg_e;

    localparam int ST_L2H_NE   = 0;
    localparam int ST_H2L_FULL = 1;
    localparam int ST_OVF      = 8;
    localparam int ST_UNF      = 9;
    localparam int ST_DOORBELL = 16;

    localparam logic [31:0] IRQ_MASK_VALID = 32'h0001_0301;

endpackage

// File: rtl/pci_mailbox_fifo.sv
// Circular-buffer 32-bit FIFO used for both mailbox directions; full/empty
// come from the registered count, so acceptance is decided on pre-edge state.
module mbox_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  PCI_CLK,
    input  logic                  PCI_RSTn,
    input  logic                  push,
    input  logic                  pop,
    input  logic [31:0]           wdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic [31:0]           head
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage is not reset; the pointers and count alone define its contents.
    always_ff @(posedge PCI_CLK) begin
        if (push_ok)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge PCI_CLK or negedge PCI_RSTn) begin
        if (!PCI_RSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pci_mailbox.sv
// PCI host/local mailbox: H2L and L2H FIFOs, doorbells and STATUS/IRQ_MASK.
// Define PCI_MBOX_IRQ_EN to drive inta; otherwise inta is 0 and IRQ_MASK reads 0.
module pci_mailbox
    import pci_mailbox_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        PCI_CLK,
    input  logic        PCI_RSTn,
    input  logic        t_sel,
    input  logic        t_wr,
    input  logic        t_rd,
    input  logic [2:0]  t_addr,
    input  logic [31:0] t_wdata,
    output logic [31:0] t_rdata,
    output logic        h2l_valid,
    output logic [31:0] h2l_data,
    input  logic        h2l_ready,
    input  logic        l2h_valid,
    input  logic [31:0] l2h_data,
    output logic        l2h_ready,
    input  logic        loc_doorbell,
    output logic        host_doorbell,
    output logic        inta
);
    // Local ports are valid/ready: a word moves on a rising edge where valid
    // and ready are both high; valid never waits on ready.
    localparam logic [DEPTH_LOG2:0] L2H_ALMOST = {1'b0, {DEPTH_LOG2{1'b1}}};

    logic                h2l_push, h2l_pop, h2l_full, h2l_empty;
    logic [DEPTH_LOG2:0] h2l_cnt;
    logic                l2h_push, l2h_pop, l2h_pop_ok, l2h_full, l2h_empty;
    logic [DEPTH_LOG2:0] l2h_cnt;
    logic [31:0]         l2h_head;
    logic                st_clr;
    logic                ovf, unf, doorbell;
    logic [31:0]         status;
    logic [31:0]         counts;
    logic [31:0]         irq_mask;

    assign h2l_push   = t_sel & t_wr & (t_addr == MBOX_H2L_DATA);
    assign h2l_pop    = h2l_valid & h2l_ready;
    assign h2l_valid  = ~h2l_empty;
    assign l2h_push   = l2h_valid & l2h_ready;
    assign l2h_pop    = t_sel & t_rd & (t_addr == MBOX_L2H_DATA);
    assign l2h_pop_ok = l2h_pop & ~l2h_empty;
    assign st_clr     = t_sel & t_wr & (t_addr == MBOX_STATUS);

    mbox_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_h2l (
        .PCI_CLK (PCI_CLK),
        .PCI_RSTn(PCI_RSTn),
        .push    (h2l_push),
        .pop     (h2l_pop),
        .wdata   (t_wdata),
        .full    (h2l_full),
        .empty   (h2l_empty),
        .count   (h2l_cnt),
        .head    (h2l_data)
    );

    mbox_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_l2h (
        .PCI_CLK (PCI_CLK),
        .PCI_RSTn(PCI_RSTn),
        .push    (l2h_push),
        .pop     (l2h_pop),
        .wdata   (l2h_data),
        .full    (l2h_full),
        .empty   (l2h_empty),
        .count   (l2h_cnt),
        .head    (l2h_head)
    );

    // Sticky bits: a set in the same cycle as a W1C wins.
    always_ff @(posedge PCI_CLK or negedge PCI_RSTn) begin
        if (!PCI_RSTn) begin
            ovf           <= 1'b0;
            unf           <= 1'b0;
            doorbell      <= 1'b0;
            host_doorbell <= 1'b0;
            l2h_ready     <= 1'b0;
        end else begin
            ovf      <= (h2l_push & h2l_full) | (ovf & ~(st_clr & t_wdata[ST_OVF]));
            unf      <= (l2h_pop & l2h_empty) | (unf & ~(st_clr & t_wdata[ST_UNF]));
            doorbell <= loc_doorbell | (doorbell & ~(st_clr & t_wdata[ST_DOORBELL]));
            host_doorbell <= t_sel & t_wr & (t_addr == MBOX_DOORBELL_OUT);
            // Ready reflects the post-edge count: not full after this edge.
            l2h_ready <= ~((l2h_full & ~l2h_pop_ok) |
                           ((l2h_cnt == L2H_ALMOST) & l2h_push & ~l2h_pop_ok));
        end
    end

    always_comb begin
        status              = '0;
        status[ST_L2H_NE]   = ~l2h_empty;
        status[ST_H2L_FULL] = h2l_full;
        status[ST_OVF]      = ovf;
        status[ST_UNF]      = unf;
        status[ST_DOORBELL] = doorbell;
    end

    assign counts = {16'(l2h_cnt), 16'(h2l_cnt)};

`ifdef PCI_MBOX_IRQ_EN
    always_ff @(posedge PCI_CLK or negedge PCI_RSTn) begin
        if (!PCI_RSTn)
            irq_mask <= '0;
        else if (t_sel & t_wr & (t_addr == MBOX_IRQ_MASK))
            irq_mask <= t_wdata & IRQ_MASK_VALID;
    end
    assign inta = |(status & irq_mask);
`else
    assign irq_mask = '0;
    assign inta     = 1'b0;
`endif

    always_comb begin
        t_rdata = '0;
        case (t_addr)
            MBOX_L2H_DATA: t_rdata = l2h_empty ? 32'h0 : l2h_head;
            MBOX_STATUS:   t_rdata = status;
            MBOX_IRQ_MASK: t_rdata = irq_mask & IRQ_MASK_VALID;
            MBOX_COUNTS:   t_rdata = counts;
            default:       t_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_pci_mailbox.sv
// Self-checking bench for pci_mailbox: queue-based reference model compared
// every cycle, plus directed literal checks of the register behaviour.
module tb_pci_mailbox;
    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 16;
`ifdef PCI_MBOX_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        PCI_CLK;
    logic        PCI_RSTn;
    logic        t_sel, t_wr, t_rd;
    logic [2:0]  t_addr;
    logic [31:0] t_wdata;
    logic [31:0] t_rdata;
    logic        h2l_valid;
    logic [31:0] h2l_data;
    logic        h2l_ready;
    logic        l2h_valid;
    logic [31:0] l2h_data;
    logic        l2h_ready;
    logic        loc_doorbell;
    logic        host_doorbell;
    logic        inta;

    pci_mailbox #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .PCI_CLK      (PCI_CLK),
        .PCI_RSTn     (PCI_RSTn),
        .t_sel        (t_sel),
        .t_wr         (t_wr),
        .t_rd         (t_rd),
        .t_addr       (t_addr),
        .t_wdata      (t_wdata),
        .t_rdata      (t_rdata),
        .h2l_valid    (h2l_valid),
        .h2l_data     (h2l_data),
        .h2l_ready    (h2l_ready),
        .l2h_valid    (l2h_valid),
        .l2h_data     (l2h_data),
        .l2h_ready    (l2h_ready),
        .loc_doorbell (loc_doorbell),
        .host_doorbell(host_doorbell),
        .inta         (inta)
    );

    // ---------------- clock / reset ----------------
    initial begin
        PCI_CLK = 1'b0;
        forever #5 PCI_CLK = ~PCI_CLK;
    end

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] h2l_exp_q[$];
    logic [31:0] l2h_exp_q[$];
    bit          m_ovf, m_unf, m_db, m_hdb, m_ready;
    logic [31:0] m_mask;

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = '0;
        s[0]  = (l2h_exp_q.size() > 0);
        s[1]  = (h2l_exp_q.size() == DEPTH);
        s[8]  = m_ovf;
        s[9]  = m_unf;
        s[16] = m_db;
        return s;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [2:0] a);
        case (a)
            3'd1:    return (l2h_exp_q.size() == 0) ? 32'h0 : l2h_exp_q[0];
            3'd2:    return m_status();
            3'd3:    return m_mask;
            3'd5:    return (32'(l2h_exp_q.size()) << 16) | 32'(h2l_exp_q.size());
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge PCI_CLK or negedge PCI_RSTn) begin
        if (!PCI_RSTn) begin
            h2l_exp_q.delete();
            l2h_exp_q.delete();
            m_ovf = 0; m_unf = 0; m_db = 0; m_hdb = 0; m_ready = 0;
            m_mask = '0;
        end else begin
            int  hn, ln;
            bit  wr, rd, clr;
            hn  = h2l_exp_q.size();
            ln  = l2h_exp_q.size();
            wr  = t_sel && t_wr;
            rd  = t_sel && t_rd;
            clr = wr && (t_addr == 3'd2);
            if (hn > 0 && h2l_ready)
                void'(h2l_exp_q.pop_front());
            if (wr && t_addr == 3'd0 && hn < DEPTH)
                h2l_exp_q.push_back(t_wdata);
            if (rd && t_addr == 3'd1 && ln > 0)
                void'(l2h_exp_q.pop_front());
            if (l2h_valid && m_ready)
                l2h_exp_q.push_back(l2h_data);
            m_ovf = (wr && t_addr == 3'd0 && hn == DEPTH) || (m_ovf && !(clr && t_wdata[8]));
            m_unf = (rd && t_addr == 3'd1 && ln == 0) || (m_unf && !(clr && t_wdata[9]));
            m_db  = loc_doorbell || (m_db && !(clr && t_wdata[16]));
            if (IRQ_EN && wr && t_addr == 3'd3)
                m_mask = t_wdata & 32'h0001_0301;
            m_hdb   = wr && (t_addr == 3'd4);
            m_ready = (l2h_exp_q.size() != DEPTH);
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        wait (cmp_en);
        forever begin
            @(negedge PCI_CLK);
            chk("h2l_valid", 32'(h2l_valid), 32'(h2l_exp_q.size() > 0));
            if (h2l_exp_q.size() > 0)
                chk("h2l_data", h2l_data, h2l_exp_q[0]);
            chk("l2h_ready", 32'(l2h_ready), 32'(m_ready));
            chk("host_doorbell", 32'(host_doorbell), 32'(m_hdb));
            chk("inta", 32'(inta), 32'(|(m_status() & m_mask)));
            chk("t_rdata", t_rdata, m_rdata(t_addr));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge PCI_CLK);
        #1;
    endtask

    task automatic host_wr(input logic [2:0] a, input logic [31:0] d);
        t_sel = 1'b1; t_wr = 1'b1; t_addr = a; t_wdata = d;
        tick();
        t_sel = 1'b0; t_wr = 1'b0;
    endtask

    task automatic host_rd(input logic [2:0] a, input logic [31:0] exp, input string name);
        t_sel = 1'b1; t_rd = 1'b1; t_addr = a;
        @(negedge PCI_CLK);
        chk(name, t_rdata, exp);
        tick();
        t_sel = 1'b0; t_rd = 1'b0;
    endtask

    task automatic peek(input logic [2:0] a, input logic [31:0] exp, input string name);
        t_addr = a;
        @(negedge PCI_CLK);
        chk(name, t_rdata, exp);
        tick();
    endtask

    task automatic do_reset();
        PCI_RSTn = 1'b0;
        repeat (2) tick();
        PCI_RSTn = 1'b1;
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        PCI_RSTn = 1'b1;
        t_sel = 0; t_wr = 0; t_rd = 0; t_addr = '0; t_wdata = '0;
        h2l_ready = 0; l2h_valid = 0; l2h_data = '0; loc_doorbell = 0;
        #1 PCI_RSTn = 1'b0;
        cmp_en = 1'b1;
        repeat (3) tick();
        PCI_RSTn = 1'b1;

        // Reset state: every offset reads 0
        chk("rst_inta", 32'(inta), 32'h0);
        for (int a = 0; a < 8; a++)
            peek(3'(a), 32'h0, $sformatf("rst_rd%0d", a));

        // Two-word H2L transfer
        host_wr(3'd0, 32'h1111_1111);
        @(negedge PCI_CLK);
        chk("h2l_valid_1st", 32'(h2l_valid), 32'h1);
        tick();
        host_wr(3'd0, 32'h2222_2222);
        h2l_ready = 1'b1;
        @(negedge PCI_CLK);
        chk("h2l_word0", h2l_data, 32'h1111_1111);
        tick();
        @(negedge PCI_CLK);
        chk("h2l_word1", h2l_data, 32'h2222_2222);
        tick();
        h2l_ready = 1'b0;
        peek(3'd5, 32'h0, "counts_drained");

        // Overflow on the 17th word
        for (int i = 1; i <= 17; i++)
            host_wr(3'd0, 32'hA000_0000 | 32'(i));
        peek(3'd5, 32'h0000_0010, "counts_full");
        peek(3'd2, 32'h0000_0102, "status_ovf");
        host_wr(3'd2, 32'h0000_0100);
        peek(3'd2, 32'h0000_0002, "status_ovf_clr");
        h2l_ready = 1'b1;
        repeat (17) tick();
        h2l_ready = 1'b0;
        peek(3'd5, 32'h0, "counts_after_drain");

        // L2H word, interrupt on non-empty, underflow
        host_wr(3'd3, 32'h0000_0001);
        l2h_data = 32'hCAFE_F00D; l2h_valid = 1'b1;
        tick();
        l2h_valid = 1'b0;
        t_addr = 3'd2;
        @(negedge PCI_CLK);
        chk("l2h_inta", 32'(inta), 32'(IRQ_EN));
        chk("l2h_status", t_rdata, 32'h0000_0001);
        tick();
        host_rd(3'd1, 32'hCAFE_F00D, "l2h_head");
        @(negedge PCI_CLK);
        chk("inta_after_rd", 32'(inta), 32'h0);
        tick();
        host_rd(3'd1, 32'h0, "l2h_empty_rd");
        peek(3'd2, 32'h0000_0200, "status_unf");
        host_wr(3'd2, 32'h0000_0200);
        peek(3'd2, 32'h0, "status_unf_clr");

        // Local doorbell, set beats simultaneous W1C
        host_wr(3'd3, 32'h0001_0000);
        loc_doorbell = 1'b1;
        tick();
        loc_doorbell = 1'b0;
        t_addr = 3'd2;
        @(negedge PCI_CLK);
        chk("db_inta", 32'(inta), 32'(IRQ_EN));
        chk("db_status", t_rdata, 32'h0001_0000);
        tick();
        t_sel = 1'b1; t_wr = 1'b1; t_addr = 3'd2; t_wdata = 32'h0001_0000; loc_doorbell = 1'b1;
        tick();
        t_sel = 1'b0; t_wr = 1'b0; loc_doorbell = 1'b0;
        peek(3'd2, 32'h0001_0000, "db_set_wins");
        host_wr(3'd2, 32'h0001_0000);
        peek(3'd2, 32'h0, "db_clr");

        // Host doorbell pulse
        host_wr(3'd4, 32'h0000_5A5A);
        @(negedge PCI_CLK);
        chk("hdb_high", 32'(host_doorbell), 32'h1);
        tick();
        @(negedge PCI_CLK);
        chk("hdb_low", 32'(host_doorbell), 32'h0);
        tick();

        // Randomized traffic, biased per block to fill and drain both FIFOs
        for (int b = 0; b < 8; b++) begin
            repeat (400) begin
                int op;
                op = $urandom_range(0, 2);
                t_sel  = ($urandom_range(0, 7) != 0);
                t_wr   = (op == 1);
                t_rd   = (op == 2);
                t_addr = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(0, 1))
                                                     : 3'($urandom_range(0, 7));
                t_wdata      = $urandom();
                h2l_ready    = ($urandom_range(0, 3) < (b % 4));
                l2h_valid    = ($urandom_range(0, 3) >= (b % 4));
                l2h_data     = $urandom();
                loc_doorbell = ($urandom_range(0, 15) == 0);
                tick();
            end
        end
        t_sel = 0; t_wr = 0; t_rd = 0; h2l_ready = 0; l2h_valid = 0; loc_doorbell = 0;
        tick();

        // Reset with data in both FIFOs
        do_reset();
        host_wr(3'd3, 32'h0000_0001);
        host_wr(3'd0, 32'h0BAD_0001);
        host_wr(3'd0, 32'h0BAD_0002);
        l2h_valid = 1'b1;
        repeat (3) begin
            l2h_data = $urandom();
            tick();
        end
        l2h_valid = 1'b0;
        peek(3'd5, 32'h0003_0002, "counts_both");
        t_addr = 3'd5;
        PCI_RSTn = 1'b0;
        #1;
        chk("rst_counts", t_rdata, 32'h0);
        chk("rst_h2l_valid", 32'(h2l_valid), 32'h0);
        chk("rst_inta_mid", 32'(inta), 32'h0);
        chk("rst_l2h_ready", 32'(l2h_ready), 32'h0);
        repeat (2) tick();
        PCI_RSTn = 1'b1;
        repeat (3) tick();
        peek(3'd2, 32'h0, "post_rst_status");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
